// File: rtl/dbg_bus_pkg.sv
// Shared constants and state encoding for the UART debug bus master.
package dbg_bus_pkg;

   localparam logic [7:0] OP_WRITE    = 8'h57;
   localparam logic [7:0] OP_READ     = 8'h52;

   localparam logic [7:0] RSP_OK      = 8'h4B;
   localparam logic [7:0] RSP_TIMEOUT = 8'h54;
   localparam logic [7:0] RSP_BADOP   = 8'h3F;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      BE,
      DATA,
      REQ,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/dbg_bus_master.sv
// UART-driven debug bridge: parses peek/poke packets from a byte stream,
// issues one single-beat transaction on the cpud bus and returns a status
// byte (plus read data) on a valid/ready transmit port. Parser, bus
// sequencer and response sequencer share one state register.
module dbg_bus_master
   import dbg_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int RX_GAP_CYCLES  = 1000000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        cpud_request,
   output logic [31:0] cpud_addr,
   output logic        cpud_write,
   output logic [3:0]  cpud_byte_enable,
   output logic [31:0] cpud_wdata,
   input  logic [31:0] cpud_rdata,
   input  logic        cpud_ack,
   output logic        busy,
   output logic [7:0]  drop_count
);

   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W = (RX_GAP_CYCLES > 0) ? $clog2(RX_GAP_CYCLES + 1) : 1;
   localparam bit GAP_EN = (RX_GAP_CYCLES > 0);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = (RX_GAP_CYCLES > 0) ? GAP_W'(RX_GAP_CYCLES - 1) : '0;

   state_t            state;
   logic              is_write;
   logic [1:0]        byte_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [31:0]       rdata_sh;
   logic [2:0]        resp_left;

   assign busy = (state != IDLE);

   // Single FSM: address/data bytes shift straight into the bus output
   // registers, so the bus fields are naturally held from REQ until ack.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         is_write         <= 1'b0;
         byte_cnt         <= '0;
         to_cnt           <= '0;
         gap_cnt          <= '0;
         rdata_sh         <= '0;
         resp_left        <= '0;
         tx_data          <= '0;
         tx_valid         <= 1'b0;
         cpud_request     <= 1'b0;
         cpud_addr        <= '0;
         cpud_write       <= 1'b0;
         cpud_byte_enable <= '0;
         cpud_wdata       <= '0;
         drop_count       <= '0;
      end else begin
         cpud_request <= 1'b0;

         if (rx_valid && (state == REQ || state == WAIT || state == RESP) &&
             drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
         end

         case (state)
            IDLE: begin
               if (rx_valid) begin
                  byte_cnt <= '0;
                  gap_cnt  <= '0;
                  if (rx_data == OP_WRITE) begin
                     is_write   <= 1'b1;
                     cpud_write <= 1'b1;
                     state      <= ADDR;
                  end else if (rx_data == OP_READ) begin
                     is_write   <= 1'b0;
                     cpud_write <= 1'b0;
                     state      <= ADDR;
                  end else begin
                     tx_data   <= RSP_BADOP;
                     tx_valid  <= 1'b1;
                     resp_left <= '0;
                     state     <= RESP;
                  end
               end
            end

            ADDR, BE, DATA: begin
               if (rx_valid) begin
                  gap_cnt <= '0;
                  if (state == ADDR) begin
                     cpud_addr <= {rx_data, cpud_addr[31:8]};
                     byte_cnt  <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd3) begin
                        if (is_write) begin
                           state <= BE;
                        end else begin
                           cpud_byte_enable <= 4'hF;
                           cpud_wdata       <= '0;
                           cpud_request     <= 1'b1;
                           to_cnt           <= '0;
                           state            <= REQ;
                        end
                     end
                  end else if (state == BE) begin
                     cpud_byte_enable <= rx_data[3:0];
                     state            <= DATA;
                  end else begin
                     cpud_wdata <= {rx_data, cpud_wdata[31:8]};
                     byte_cnt   <= byte_cnt + 2'd1;
                     if (byte_cnt == 2'd3) begin
                        cpud_request <= 1'b1;
                        to_cnt       <= '0;
                        state        <= REQ;
                     end
                  end
               end else if (GAP_EN && gap_cnt == GAP_LAST) begin
                  state <= IDLE;
               end else if (GAP_EN) begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end

            REQ: begin
               state <= WAIT;
            end

            WAIT: begin
               if (cpud_ack) begin
                  rdata_sh  <= cpud_rdata;
                  tx_data   <= RSP_OK;
                  tx_valid  <= 1'b1;
                  resp_left <= is_write ? 3'd0 : 3'd4;
                  state     <= RESP;
               end else if (to_cnt == TO_LAST) begin
                  tx_data   <= RSP_TIMEOUT;
                  tx_valid  <= 1'b1;
                  resp_left <= '0;
                  state     <= RESP;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end

            RESP: begin
               if (tx_valid && tx_ready) begin
                  if (resp_left == 3'd0) begin
                     tx_valid <= 1'b0;
                     tx_data  <= '0;
                     state    <= IDLE;
                  end else begin
                     tx_data   <= rdata_sh[7:0];
                     rdata_sh  <= {8'h00, rdata_sh[31:8]};
                     resp_left <= resp_left - 3'd1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
